mig_ui_responder: RTL and testbench

Synthesizable responder for the Xilinx MIG user interface (UI) in the PCIe/MIG accelerator design. It stands in for the DDR controller beneath `accelerator_ctl`: it accepts `app_*` commands and write data, stores words in an internal BRAM array, and returns read data in order after a fixed latency. It is used in simulation benches and in memoryless FPGA bring-up builds. Its configurable back-pressure exercises the controller's handshake paths.

---
 rtl/mig_ui_pkg.sv | 25 ++
 rtl/mig_ui_responder_fifo.sv | 54 +++++
 rtl/mig_ui_responder.sv | 179 +++++++++++++++++
 tb/tb_mig_ui_responder.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_ui_pkg.sv
// Shared types for the MIG UI responder.
// Command codes, request bundle and decode helper.
package mig_ui_pkg;

  localparam int UI_ADDR_W = 28;
  localparam int UI_DATA_W = 128;
  localparam int UI_IDX_W  = UI_ADDR_W - 3;

  typedef enum logic [2:0] {
    UI_WR = 3'b000,
    UI_RD = 3'b001
  } ui_cmd_t;

  typedef logic [UI_IDX_W-1:0] ui_idx_t;

  typedef struct packed {
    ui_cmd_t cmd;
    ui_idx_t word_idx;
  } ui_req_t;

  function automatic logic is_legal(input logic [2:0] c);
    return (c == UI_WR) || (c == UI_RD);
  endfunction

endpackage

// File: rtl/mig_ui_responder_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit; occupancy is their difference.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  next_count;
  logic         do_push;
  logic         do_pop;

  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign count      = wptr - rptr;
  assign next_count = count
                    + (AW+1)'(do_push)
                    - (AW+1)'(do_pop);
  assign dout       = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      full  <= (next_count == FULL_CNT);
      empty <= (next_count == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mig_ui_responder.sv
// MIG UI responder: in-order command queue, write-data FIFO,
// BRAM word store and fixed-latency read return.
import mig_ui_pkg::*;

module mig_ui_responder #(
  parameter int ADDR_W       = UI_ADDR_W,
  parameter int DATA_W       = UI_DATA_W,
  parameter int MEM_DEPTH    = 1024,
  parameter int RD_LAT       = 4,
  parameter int Q_DEPTH      = 4,
  parameter int CALIB_CYCLES = 16,
  parameter int STALL_EVERY  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                app_en,
  input  logic [2:0]          app_cmd,
  input  logic [ADDR_W-1:0]   app_addr,
  output logic                app_rdy,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_rdy,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                init_calib_complete,
  output logic                err_illegal_cmd
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam int QW    = $clog2(Q_DEPTH);
  localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
  localparam logic [CAL_W-1:0] CAL_LAST =
    CAL_W'(CALIB_CYCLES - 1);
  localparam logic [15:0] STALL_N = 16'(STALL_EVERY);

  ui_req_t              req_in;
  ui_req_t              head;
  logic                 cmd_acc;
  logic                 cq_push;
  logic                 cq_full;
  logic                 cq_empty;
  logic [QW:0]          cq_count;
  logic                 wq_push;
  logic                 wq_full;
  logic                 wq_empty;
  logic [QW:0]          wq_count;
  logic [BE_W+DATA_W-1:0] wq_dout;
  logic [DATA_W-1:0]    wdata;
  logic [BE_W-1:0]      wmask;
  logic [IDX_W-1:0]     head_idx;
  logic                 exec_wr;
  logic                 exec_rd;
  logic [CAL_W-1:0]     cal_cnt;
  logic [15:0]          stall_cnt;
  logic                 stall_cycle;
  logic [RD_LAT-1:0]    pv;
  logic [DATA_W-1:0]    pd [RD_LAT];
  logic [DATA_W-1:0]    mem [MEM_DEPTH];
  logic                 unused_bits;

  // Ready terms come only from registered state.
  assign app_rdy     = init_calib_complete & ~cq_full
                     & ~stall_cycle;
  assign app_wdf_rdy = init_calib_complete & ~wq_full;
  assign cmd_acc     = app_en & app_rdy;
  assign cq_push     = cmd_acc & is_legal(app_cmd);
  assign wq_push     = app_wdf_wren & app_wdf_rdy;

  always_comb begin
    req_in          = '0;
    req_in.cmd      = ui_cmd_t'(app_cmd);
    req_in.word_idx = ui_idx_t'(app_addr[3 +: IDX_W]);
  end

  sync_fifo #(
    .W     ($bits(ui_req_t)),
    .DEPTH (Q_DEPTH)
  ) u_cmd_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cq_push),
    .din   (req_in),
    .pop   (exec_wr | exec_rd),
    .dout  (head),
    .full  (cq_full),
    .empty (cq_empty),
    .count (cq_count)
  );

  sync_fifo #(
    .W     (BE_W + DATA_W),
    .DEPTH (Q_DEPTH)
  ) u_wdf_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wq_push),
    .din   ({app_wdf_mask, app_wdf_data}),
    .pop   (exec_wr),
    .dout  (wq_dout),
    .full  (wq_full),
    .empty (wq_empty),
    .count (wq_count)
  );

  assign wdata    = wq_dout[DATA_W-1:0];
  assign wmask    = wq_dout[DATA_W +: BE_W];
  assign head_idx = head.word_idx[IDX_W-1:0];

  // A WRITE without data holds the head and everything behind it.
  always_comb begin
    exec_wr = 1'b0;
    exec_rd = 1'b0;
    if (rst_n && !cq_empty) begin
      unique case (1'b1)
        head.cmd == UI_WR: exec_wr = ~wq_empty;
        head.cmd == UI_RD: exec_rd = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (exec_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (!wmask[b])
          mem[head_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    pd[0] <= mem[head_idx];
    for (int k = 1; k < RD_LAT; k++)
      pd[k] <= pd[k-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cal_cnt             <= '0;
      init_calib_complete <= 1'b0;
      stall_cnt           <= '0;
      stall_cycle         <= 1'b0;
      err_illegal_cmd     <= 1'b0;
      pv                  <= '0;
      app_rd_data_valid   <= 1'b0;
      app_rd_data_end     <= 1'b0;
      app_rd_data         <= '0;
    end else begin
      if (!init_calib_complete) begin
        cal_cnt <= cal_cnt + 1'b1;
        if (cal_cnt == CAL_LAST)
          init_calib_complete <= 1'b1;
      end
      stall_cycle <= 1'b0;
      if (cmd_acc && STALL_N != 16'd0) begin
        if (stall_cnt == STALL_N - 16'd1) begin
          stall_cnt   <= '0;
          stall_cycle <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + 16'd1;
        end
      end
      if (cmd_acc && !is_legal(app_cmd))
        err_illegal_cmd <= 1'b1;
      pv[0] <= exec_rd;
      for (int k = 1; k < RD_LAT; k++)
        pv[k] <= pv[k-1];
      app_rd_data_valid <= pv[RD_LAT-1];
      app_rd_data_end   <= pv[RD_LAT-1];
      if (pv[RD_LAT-1])
        app_rd_data <= pd[RD_LAT-1];
    end
  end

  assign unused_bits = ^{app_wdf_end, head,
                         cq_count, wq_count};

endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed bench for mig_ui_responder.
// One task per scenario; expectations are hand-computed.
module tb_mig_ui_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic         app_rdy;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic [127:0] app_rd_data;
  logic         init_calib_complete;
  logic         err_illegal_cmd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] rd_q [$];
  int           rd_t [$];
  logic         rd_e [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      rd_q.push_back(app_rd_data);
      rd_t.push_back(cyc);
      rd_e.push_back(app_rd_data_end);
    end
  end

  mig_ui_responder #(
    .ADDR_W       (28),
    .DATA_W       (128),
    .MEM_DEPTH    (1024),
    .RD_LAT       (4),
    .Q_DEPTH      (4),
    .CALIB_CYCLES (16),
    .STALL_EVERY  (3)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .app_rd_data         (app_rd_data),
    .init_calib_complete (init_calib_complete),
    .err_illegal_cmd     (err_illegal_cmd)
  );

  task automatic clear_rd();
    rd_q.delete();
    rd_t.delete();
    rd_e.delete();
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic cmd_go(input logic [2:0] c,
                        input logic [27:0] a,
                        output int t);
    int n;
    n = 0;
    app_en   = 1'b1;
    app_cmd  = c;
    app_addr = a;
    while (!app_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout cmd=%0d addr=%h", c, a);
    end
    @(negedge clk);
    t = cyc;
    app_en = 1'b0;
  endtask

  task automatic wdf_go(input logic [127:0] d,
                        input logic [15:0] m);
    int n;
    n = 0;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_data = d;
    app_wdf_mask = m;
    while (!app_wdf_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wdf_timeout data=%h", d);
    end
    @(negedge clk);
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!init_calib_complete && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL calib_timeout got=0 exp=1");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({app_rdy, app_wdf_rdy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_rdy got=%b exp=00",
               {app_rdy, app_wdf_rdy});
    end
    checks++;
    if ({app_rd_data_valid, app_rd_data_end} !== 2'b00) begin
      errors++;
      $display("FAIL rst_valid got=%b exp=00",
               {app_rd_data_valid, app_rd_data_end});
    end
    checks++;
    if (app_rd_data !== 128'h0) begin
      errors++;
      $display("FAIL rst_data got=%h exp=0", app_rd_data);
    end
    checks++;
    if ({init_calib_complete, err_illegal_cmd} !== 2'b00) begin
      errors++;
      $display("FAIL rst_flags got=%b exp=00",
               {init_calib_complete, err_illegal_cmd});
    end
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if ({init_calib_complete, app_rdy} !== 2'b00) begin
      errors++;
      $display("FAIL calib_early got=%b exp=00",
               {init_calib_complete, app_rdy});
    end
    @(negedge clk);
    checks++;
    if ({init_calib_complete, app_rdy, app_wdf_rdy}
        !== 3'b111) begin
      errors++;
      $display("FAIL calib_edge16 got=%b exp=111",
               {init_calib_complete, app_rdy, app_wdf_rdy});
    end
  endtask

  task automatic test_write_read();
    int t;
    clear_rd();
    wdf_go(128'hDEADBEEF, 16'h0000);
    cmd_go(3'b000, 28'h40, t);
    cmd_go(3'b001, 28'h40, t);
    repeat (10) @(negedge clk);
    checks++;
    if (rd_q.size() != 1) begin
      errors++;
      $display("FAIL wr_rd_count got=%0d exp=1", rd_q.size());
    end
    if (rd_q.size() >= 1) begin
      checks++;
      if (rd_q[0] !== 128'hDEADBEEF) begin
        errors++;
        $display("FAIL wr_rd_data got=%h exp=deadbeef",
                 rd_q[0]);
      end
      checks++;
      if (rd_t[0] - t != 5) begin
        errors++;
        $display("FAIL wr_rd_latency got=%0d exp=5",
                 rd_t[0] - t);
      end
      checks++;
      if (rd_e[0] !== 1'b1) begin
        errors++;
        $display("FAIL wr_rd_end got=%b exp=1", rd_e[0]);
      end
    end
  endtask

  task automatic test_byte_mask();
    int t;
    clear_rd();
    wdf_go(128'h11223344, 16'h0000);
    cmd_go(3'b000, 28'h80, t);
    wdf_go(128'hFFFFFFFF, 16'hFFFE);
    cmd_go(3'b000, 28'h80, t);
    cmd_go(3'b001, 28'h80, t);
    repeat (10) @(negedge clk);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== 128'h112233FF) begin
      errors++;
      $display("FAIL byte_mask got=%h n=%0d exp=112233ff",
               rd_q.size() ? rd_q[0] : 128'h0, rd_q.size());
    end
  endtask

  task automatic test_illegal();
    int t;
    clear_rd();
    checks++;
    if (err_illegal_cmd !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pre got=%b exp=0", err_illegal_cmd);
    end
    cmd_go(3'b111, 28'h0, t);
    checks++;
    if (err_illegal_cmd !== 1'b1) begin
      errors++;
      $display("FAIL illegal_set got=%b exp=1", err_illegal_cmd);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (err_illegal_cmd !== 1'b1 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_sticky got=%b/%0d exp=1/0",
               err_illegal_cmd, rd_q.size());
    end
  endtask

  task automatic test_back_pressure();
    int t;
    for (int i = 0; i < 4; i++)
      wdf_go(128'hB0 + 128'(i), 16'h0000);
    checks++;
    if (app_wdf_rdy !== 1'b0) begin
      errors++;
      $display("FAIL wdf_full got=%b exp=0", app_wdf_rdy);
    end
    app_wdf_wren = 1'b1;
    app_wdf_data = 128'hB4;
    app_wdf_mask = 16'h0000;
    @(negedge clk);
    checks++;
    if (app_wdf_rdy !== 1'b0) begin
      errors++;
      $display("FAIL wdf_beat5 got=%b exp=0", app_wdf_rdy);
    end
    app_wdf_wren = 1'b0;
    for (int i = 0; i < 4; i++)
      cmd_go(3'b000, 28'h100 + 28'(i * 8), t);
    repeat (4) @(negedge clk);
    checks++;
    if (app_wdf_rdy !== 1'b1) begin
      errors++;
      $display("FAIL wdf_drain got=%b exp=1", app_wdf_rdy);
    end
    clear_rd();
    cmd_go(3'b001, 28'h100, t);
    cmd_go(3'b001, 28'h118, t);
    repeat (10) @(negedge clk);
    checks++;
    if (rd_q.size() != 2 || rd_q[0] !== 128'hB0
        || rd_q[1] !== 128'hB3) begin
      errors++;
      $display("FAIL wdf_order got=%0d %h %h exp=2 b0 b3",
               rd_q.size(), rd_q.size() > 0 ? rd_q[0] : 128'h0,
               rd_q.size() > 1 ? rd_q[1] : 128'h0);
    end
    clear_rd();
    cmd_go(3'b000, 28'h200, t);
    for (int i = 0; i < 3; i++)
      cmd_go(3'b001, 28'h200, t);
    app_en   = 1'b1;
    app_cmd  = 3'b001;
    app_addr = 28'h200;
    repeat (3) @(negedge clk);
    checks++;
    if (app_rdy !== 1'b0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL cmd_full got=%b/%0d exp=0/0",
               app_rdy, rd_q.size());
    end
    app_en = 1'b0;
    wdf_go(128'hCAFE, 16'h0000);
    repeat (12) @(negedge clk);
    checks++;
    if (rd_q.size() != 3) begin
      errors++;
      $display("FAIL raw_count got=%0d exp=3", rd_q.size());
    end
    for (int i = 0; i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== 128'hCAFE) begin
        errors++;
        $display("FAIL raw_data%0d got=%h exp=cafe", i, rd_q[i]);
      end
    end
  endtask

  task automatic test_stall_order();
    int t;
    int a [6];
    int gap_exp [5] = '{1, 1, 2, 1, 1};
    for (int i = 0; i < 6; i++) begin
      wdf_go(128'hA0 + 128'(i), 16'h0000);
      cmd_go(3'b000, 28'(i * 8), t);
    end
    repeat (5) @(negedge clk);
    do_reset();
    clear_rd();
    for (int i = 0; i < 6; i++)
      cmd_go(3'b001, 28'(i * 8), a[i]);
    checks++;
    if (app_rdy !== 1'b0) begin
      errors++;
      $display("FAIL stall6_low got=%b exp=0", app_rdy);
    end
    @(negedge clk);
    checks++;
    if (app_rdy !== 1'b1) begin
      errors++;
      $display("FAIL stall6_one got=%b exp=1", app_rdy);
    end
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (a[i] - a[i-1] != gap_exp[i-1]) begin
        errors++;
        $display("FAIL stall_gap%0d got=%0d exp=%0d",
                 i, a[i] - a[i-1], gap_exp[i-1]);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rd_q.size() != 6) begin
      errors++;
      $display("FAIL order_count got=%0d exp=6", rd_q.size());
    end
    for (int i = 0; i < rd_q.size() && i < 6; i++) begin
      checks++;
      if (rd_q[i] !== 128'hA0 + 128'(i)
          || rd_t[i] != a[i] + 5) begin
        errors++;
        $display("FAIL order%0d got=%h@%0d exp=%h@%0d",
                 i, rd_q[i], rd_t[i],
                 128'hA0 + 128'(i), a[i] + 5);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int t;
    int n;
    clear_rd();
    for (int i = 0; i < 3; i++)
      cmd_go(3'b001, 28'(i * 8), t);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({app_rd_data_valid, app_rdy} !== 2'b00
        || app_rd_data !== 128'h0) begin
      errors++;
      $display("FAIL mid_rst_out got=%b %h exp=00 0",
               {app_rd_data_valid, app_rdy}, app_rd_data);
    end
    rst_n = 1'b1;
    n = 0;
    while (!init_calib_complete && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rd_q.size() != 0 || n != 16) begin
      errors++;
      $display("FAIL mid_rst_flush got=%0d cal=%0d exp=0 cal=16",
               rd_q.size(), n);
    end
    for (int i = 0; i < 3; i++)
      cmd_go(3'b001, 28'(i * 8), t);
    repeat (10) @(negedge clk);
    checks++;
    if (rd_q.size() != 3) begin
      errors++;
      $display("FAIL retain_count got=%0d exp=3", rd_q.size());
    end
    for (int i = 0; i < rd_q.size() && i < 3; i++) begin
      checks++;
      if (rd_q[i] !== 128'hA0 + 128'(i)) begin
        errors++;
        $display("FAIL retain%0d got=%h exp=%h",
                 i, rd_q[i], 128'hA0 + 128'(i));
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    app_wdf_data = '0;
    app_wdf_mask = '0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_illegal();
    test_back_pressure();
    test_stall_order();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
